// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the ALU command sequencer: command kinds,
// FSM states and the 13-bit packed command word held in the FIFO.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      EXEC = 2'b00,
      LOAD = 2'b01,
      READ = 2'b10,
      NOP  = 2'b11
   } cmd_kind_e;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      ISSUE,
      WRITE,
      RESP
   } state_e;

   typedef struct packed {
      cmd_kind_e   kind;
      logic [2:0]  op;
      logic [7:0]  data;
   } cmd_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command/response handshake bundle for the ALU sequencer.
// master = command front end, slave = sequencer.
interface alu_seq_ctrl_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_kind;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_zero;

   modport master (
      output cmd_valid, cmd_kind, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_zero
   );

   modport slave (
      input  cmd_valid, cmd_kind, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_zero
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of cmd_t. Ports: clk, rst, push, pop, din,
// head (oldest entry), full, empty, full_next (full after this edge).
module alu_cmd_fifo
   import alu_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  cmd_t din,
   output cmd_t head,
   output logic full,
   output logic empty,
   output logic full_next
);

   localparam int AW = $clog2(DEPTH);

   cmd_t           mem_q [DEPTH];
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW-1:0]  rptr_q, rptr_d;
   logic [AW:0]    cnt_q, cnt_d;
   logic           wr, rd;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rptr_q];
   assign wr    = push && !full;
   assign rd    = pop && !empty;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (wr) wptr_d = wptr_q + 1'b1;
      if (rd) rptr_d = rptr_q + 1'b1;
      if (wr && !rd) cnt_d = cnt_q + 1'b1;
      if (rd && !wr) cnt_d = cnt_q - 1'b1;
   end

   assign full_next = (cnt_d == (AW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU command sequencer: queues commands, runs them one at a time
// through alu/accum and returns a response. Ports: clk, rst, bus
// (cmd/rsp handshakes), alu_* and acc_* datapath controls, busy.
module alu_seq_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter int         ALU_LAT    = 1,
   parameter logic [7:0] ACC_INIT   = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_seq_ctrl_if.slave        bus,
   output logic [2:0]           alu_opcode,
   output logic [7:0]           alu_ain,
   output logic [7:0]           alu_bin,
   input  logic [7:0]           alu_out,
   input  logic                 alu_zero,
   output logic                 acc_load,
   output logic [7:0]           acc_datain,
   input  logic [7:0]           acc_dataout,
   output logic                 busy
);

   localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_e        state_q, state_d;
   cmd_t          cmd_q, cmd_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [7:0]    res_q, res_d;
   logic          rzero_q, rzero_d;
   logic [7:0]    rsp_data_q, rsp_data_d;
   logic          rsp_zero_q, rsp_zero_d;
   logic          cmd_ready_q, cmd_ready_d;

   logic          push, pop;
   logic          fifo_full, fifo_empty, fifo_full_next;
   cmd_t          fifo_din, head;

   assign fifo_din = '{
      kind: cmd_kind_e'(bus.cmd_kind),
      op:   bus.cmd_op,
      data: bus.cmd_data
   };
   assign push = bus.cmd_valid && cmd_ready_q && !fifo_full;

   alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .din       (fifo_din),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .full_next (fifo_full_next)
   );

   assign alu_ain       = acc_dataout;
   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign busy          = (state_q != IDLE) || !fifo_empty;

   // Strobes are masked while rst is high so an aborted command
   // never writes the accumulator or raises a response.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      lat_d        = lat_q;
      res_d        = res_q;
      rzero_d      = rzero_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      pop          = 1'b0;
      acc_load     = 1'b0;
      acc_datain   = '0;
      alu_opcode   = '0;
      alu_bin      = '0;
      bus.rsp_valid = 1'b0;
      if (!rst) begin
         unique case (state_q)
            INIT: begin
               acc_load   = 1'b1;
               acc_datain = ACC_INIT;
               state_d    = IDLE;
            end
            IDLE: begin
               if (!fifo_empty) begin
                  pop   = 1'b1;
                  cmd_d = head;
                  unique case (1'b1)
                     head.kind == EXEC: begin
                        state_d = ISSUE;
                        lat_d   = LW'(ALU_LAT - 1);
                     end
                     head.kind == LOAD: state_d = WRITE;
                     head.kind == READ: begin
                        state_d    = RESP;
                        rsp_data_d = acc_dataout;
                        rsp_zero_d = (acc_dataout == '0);
                     end
                     head.kind == NOP:  state_d = IDLE;
                  endcase
               end
            end
            ISSUE: begin
               alu_opcode = cmd_q.op;
               alu_bin    = cmd_q.data;
               if (lat_q == '0) begin
                  res_d   = alu_out;
                  rzero_d = alu_zero;
                  state_d = WRITE;
               end else begin
                  lat_d = lat_q - 1'b1;
               end
            end
            WRITE: begin
               acc_load = 1'b1;
               if (cmd_q.kind == EXEC) begin
                  acc_datain = res_q;
                  rsp_zero_d = rzero_q;
               end else begin
                  acc_datain = cmd_q.data;
                  rsp_zero_d = (cmd_q.data == '0);
               end
               rsp_data_d = acc_datain;
               state_d    = RESP;
            end
            RESP: begin
               bus.rsp_valid = 1'b1;
               if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = INIT;
         endcase
      end
   end

   // Registered ready tracks the FIFO level after this edge, so a
   // pop while full does not reopen the port in the same cycle.
   assign cmd_ready_d = (state_d != INIT) && !fifo_full_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         cmd_q       <= '0;
         lat_q       <= '0;
         res_q       <= '0;
         rzero_q     <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         lat_q       <= lat_d;
         res_q       <= res_d;
         rzero_q     <= rzero_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a stub ALU and accumulator.
// A transaction-level model predicts accumulator writes and responses.
module tb_alu_seq_ctrl;
   import alu_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_seq_ctrl_if bus();

   logic [2:0] alu_opcode;
   logic [7:0] alu_ain, alu_bin, alu_out;
   logic       alu_zero, acc_load, busy;
   logic [7:0] acc_datain, acc_dataout;
   logic [7:0] acc_q = 8'h00;

   function automatic logic [7:0] alu_f(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a + b;
         3'd2:    return a - b;
         3'd3:    return a ^ b;
         default: return b;
      endcase
   endfunction

   assign alu_out     = alu_f(alu_opcode, alu_ain, alu_bin);
   assign alu_zero    = (alu_out == 8'h00);
   assign acc_dataout = acc_q;
   always @(posedge clk) if (acc_load) acc_q <= acc_datain;

   alu_seq_ctrl #(.FIFO_DEPTH(4), .ALU_LAT(1), .ACC_INIT(8'hFF)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .alu_opcode  (alu_opcode),
      .alu_ain     (alu_ain),
      .alu_bin     (alu_bin),
      .alu_out     (alu_out),
      .alu_zero    (alu_zero),
      .acc_load    (acc_load),
      .acc_datain  (acc_datain),
      .acc_dataout (acc_dataout),
      .busy        (busy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Model: commands complete in order, so the accumulator value each
   // command sees is known at acceptance time.
   logic [8:0] exp_rsp [$];
   logic [7:0] exp_wr  [$];
   logic [7:0] macc;
   logic       hold = 1'b0;
   logic [7:0] hold_d;
   logic       hold_z;

   always @(negedge clk) begin
      logic [8:0] e;
      logic [7:0] r;
      if (rst) begin
         exp_rsp.delete();
         exp_wr.delete();
         exp_wr.push_back(8'hFF);
         macc = 8'hFF;
         hold = 1'b0;
         check("rst_acc_load", acc_load, 0);
         check("rst_rsp_valid", bus.rsp_valid, 0);
      end else begin
         if (acc_load) begin
            if (exp_wr.size() == 0) fail_now("acc_load_unexpected");
            else check("acc_wr", acc_datain, exp_wr.pop_front());
         end
         check("alu_ain", alu_ain, acc_q);
         if (bus.rsp_valid) begin
            if (hold) begin
               check("rsp_stable_data", bus.rsp_data, hold_d);
               check("rsp_stable_zero", bus.rsp_zero, hold_z);
            end
            if (bus.rsp_ready) begin
               if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
               else begin
                  e = exp_rsp.pop_front();
                  check("rsp_data", bus.rsp_data, e[7:0]);
                  check("rsp_zero", bus.rsp_zero, e[8]);
               end
            end
         end else if (hold) begin
            fail_now("rsp_dropped");
         end
         hold   = bus.rsp_valid && !bus.rsp_ready;
         hold_d = bus.rsp_data;
         hold_z = bus.rsp_zero;
         if (bus.cmd_valid && bus.cmd_ready) begin
            case (cmd_kind_e'(bus.cmd_kind))
               EXEC: begin
                  r    = alu_f(bus.cmd_op, macc, bus.cmd_data);
                  macc = r;
                  exp_wr.push_back(r);
                  exp_rsp.push_back({r == 8'h00, r});
               end
               LOAD: begin
                  macc = bus.cmd_data;
                  exp_wr.push_back(bus.cmd_data);
                  exp_rsp.push_back({bus.cmd_data == 8'h00, bus.cmd_data});
               end
               READ: exp_rsp.push_back({macc == 8'h00, macc});
               default: ;
            endcase
         end
      end
   end

   task automatic send(input cmd_kind_e k, input logic [2:0] op,
                       input logic [7:0] d);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_kind  = k;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.cmd_ready;
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      if (!ok) fail_now("cmd_accept_timeout");
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = !busy && !bus.rsp_valid;
      end
      if (!ok) fail_now("idle_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_kind  = 2'b00;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 8'h00;
      bus.rsp_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_cmd_ready", bus.cmd_ready, 0);
      check("reset_acc_load", acc_load, 0);
      check("reset_rsp_data", bus.rsp_data, 0);
      check("reset_rsp_zero", bus.rsp_zero, 0);
      check("reset_alu_opcode", alu_opcode, 0);
      check("reset_alu_bin", alu_bin, 0);
      check("reset_acc_datain", acc_datain, 0);
      check("reset_busy", busy, 1);

      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("init_acc_load", acc_load, 1);
      check("init_acc_datain", acc_datain, 8'hFF);
      check("init_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      check("idle_cmd_ready", bus.cmd_ready, 1);
      check("idle_acc_load", acc_load, 0);
      check("idle_busy", busy, 0);

      // LOAD 05: write one cycle after pop, response after two.
      send(LOAD, 3'd0, 8'h05);
      @(negedge clk);
      check("load_pop_acc_load", acc_load, 0);
      @(negedge clk);
      check("load_acc_load", acc_load, 1);
      check("load_acc_datain", acc_datain, 8'h05);
      @(negedge clk);
      check("load_rsp_valid", bus.rsp_valid, 1);
      check("load_rsp_data", bus.rsp_data, 8'h05);
      check("load_rsp_zero", bus.rsp_zero, 0);
      wait_idle();

      // READ returns the accumulator one cycle after pop.
      send(READ, 3'd0, 8'h00);
      @(negedge clk);
      check("read_pop_rsp_valid", bus.rsp_valid, 0);
      @(negedge clk);
      check("read_rsp_valid", bus.rsp_valid, 1);
      check("read_rsp_data", bus.rsp_data, 8'h05);
      wait_idle();

      // EXEC add 03 to 05 -> 08; response three cycles after pop.
      send(EXEC, 3'd1, 8'h03);
      @(negedge clk);
      check("exec_pop_alu_bin", alu_bin, 8'h00);
      check("exec_pop_rsp_valid", bus.rsp_valid, 0);
      @(negedge clk);
      check("exec_issue_alu_bin", alu_bin, 8'h03);
      check("exec_issue_opcode", alu_opcode, 3'd1);
      check("exec_issue_acc_load", acc_load, 0);
      @(negedge clk);
      check("exec_write_alu_bin", alu_bin, 8'h00);
      check("exec_write_acc_load", acc_load, 1);
      check("exec_write_datain", acc_datain, 8'h08);
      check("exec_write_rsp_valid", bus.rsp_valid, 0);
      @(negedge clk);
      check("exec_rsp_valid", bus.rsp_valid, 1);
      check("exec_rsp_data", bus.rsp_data, 8'h08);
      check("exec_rsp_zero", bus.rsp_zero, 0);
      wait_idle();

      // Backpressure: five commands with the response port stalled.
      bus.rsp_ready = 1'b0;
      send(LOAD, 3'd0, 8'h11);
      send(LOAD, 3'd0, 8'h22);
      send(READ, 3'd0, 8'h00);
      send(EXEC, 3'd0, 8'h0F);
      send(LOAD, 3'd0, 8'h00);
      @(negedge clk);
      check("full_cmd_ready", bus.cmd_ready, 0);
      check("full_rsp_valid", bus.rsp_valid, 1);
      check("full_rsp_data", bus.rsp_data, 8'h11);
      check("full_busy", busy, 1);
      repeat (5) @(negedge clk);
      check("full_cmd_ready_hold", bus.cmd_ready, 0);
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("drain_resp_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      check("drain_pop_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      check("drain_after_cmd_ready", bus.cmd_ready, 1);
      wait_idle();
      check("drain_acc", acc_q, 8'h00);

      // NOP among LOADs produces neither a write nor a response.
      send(LOAD, 3'd0, 8'h33);
      send(NOP, 3'd5, 8'hAA);
      send(LOAD, 3'd0, 8'h44);
      send(READ, 3'd0, 8'h00);
      wait_idle();
      check("nop_acc", acc_q, 8'h44);
      check("nop_last_rsp", bus.rsp_data, 8'h44);

      // Reset during ISSUE of an EXEC with another command queued.
      send(EXEC, 3'd1, 8'h01);
      bus.cmd_valid = 1'b1;
      bus.cmd_kind  = LOAD;
      bus.cmd_data  = 8'h77;
      @(negedge clk);
      check("abort_push_ready", bus.cmd_ready, 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort_alu_bin", alu_bin, 8'h00);
      check("abort_acc_load", acc_load, 0);
      @(negedge clk);
      check("abort_busy", busy, 1);
      check("abort_cmd_ready", bus.cmd_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reinit_acc_load", acc_load, 1);
      check("reinit_acc_datain", acc_datain, 8'hFF);
      @(negedge clk);
      check("reinit_fifo_empty", busy, 0);
      check("reinit_rsp_valid", bus.rsp_valid, 0);
      check("reinit_acc", acc_q, 8'hFF);

      // FF xor FF gives a zero result.
      send(EXEC, 3'd3, 8'hFF);
      @(negedge clk);
      @(negedge clk);
      check("xor_issue_alu_bin", alu_bin, 8'hFF);
      @(negedge clk);
      check("xor_write_datain", acc_datain, 8'h00);
      @(negedge clk);
      check("xor_rsp_valid", bus.rsp_valid, 1);
      check("xor_rsp_zero", bus.rsp_zero, 1);
      wait_idle();

      check("left_rsp", exp_rsp.size(), 0);
      check("left_wr", exp_wr.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
